// File: rtl/mor1kx_wb_arb.sv
// Two-to-one Wishbone B3 arbiter: mor1kx iwbm (m0) and dwbm (m1) share one downstream port.
// Registered round-robin grant held for the whole CYC envelope; forwarding is a pure
// combinational mux on the grant state.
// Optional stuck-slave watchdog enabled by defining MOR1KX_WB_ARB_TIMEOUT_EN.
module mor1kx_wb_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rstn,
  // requester 0 (iwbm)
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // requester 1 (dwbm)
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared downstream port
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // One-hot encoding so the state register doubles as the grant output.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } state_e;

  state_e state_q;
  logic   last_q;
  logic   fire;

`ifdef MOR1KX_WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_cyc;
  logic             gnt_stb;

  assign gnt_cyc = (state_q == StGnt0) ? m0_cyc_i : (state_q == StGnt1) ? m1_cyc_i : 1'b0;
  assign gnt_stb = (state_q == StGnt0) ? m0_stb_i : (state_q == StGnt1) ? m1_stb_i : 1'b0;
  assign fire    = (state_q != StIdle) && (cnt_q == CNT_W'(TIMEOUT));

  // Watchdog: count unanswered strobe cycles; CYC low covers every state change.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (fire || !gnt_cyc || !gnt_stb || s_ack_i || s_err_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign fire = 1'b0;
`endif

  // Grant FSM: round-robin on ties, grant held until the owner drops CYC.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= StGnt0;
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= StGnt1;
            last_q  <= 1'b1;
          end
        end
        StGnt0:  if (!m0_cyc_i) state_q <= StIdle;
        StGnt1:  if (!m1_cyc_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_o   = state_q;
  assign timeout_o = fire;
  // Read data is broadcast; ACK alone qualifies it.
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;

  // Forwarding mux; a firing watchdog kills the beat and answers with ERR.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i & ~fire;
        s_stb_o  = m0_stb_i & ~fire;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i & ~fire;
        m0_err_o = s_err_i | fire;
      end
      StGnt1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~fire;
        s_stb_o  = m1_stb_i & ~fire;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i & ~fire;
        m1_err_o = s_err_i | fire;
      end
      default: ;
    endcase
  end

endmodule
